// File: rtl/raw_stream_tx_if.sv
// raw_stream_tx_if: upstream pixel valid/ready handshake between the source FIFO and raw_stream_tx
// Signals:
//   src_data  - upstream pixel
//   src_valid - source has a pixel this cycle
//   src_ready - sink takes src_data on this edge
// Modports: master = pixel source, slave = raw_stream_tx
interface raw_stream_tx_if #(
    parameter int BITS = 8
);
    logic [BITS-1:0] src_data;
    logic            src_valid;
    logic            src_ready;
    modport master (output src_data, output src_valid, input src_ready);
    modport slave  (input src_data, input src_valid, output src_ready);
endinterface

// File: rtl/raw_stream_tx.sv
// raw_stream_tx: frame-timing transmitter producing a gap-free raw Bayer stream with H/V blanking
// Ports:
//   pclk, rst_n         - pixel clock, asynchronous active-low reset
//   enable              - run request, sampled only at frame boundaries
//   src                 - upstream pixel handshake (raw_stream_tx_if.slave)
//   per_raw_data/clken  - registered output pixel and active-pixel strobe
//   frame_start         - pulse with first pixel of a frame
//   line_end            - pulse with last pixel of each line
//   frame_done          - pulse with last pixel of a frame
//   underflow           - sticky flag, source was empty during an active cycle
//   underflow_clr       - synchronous clear of underflow
// Optional build macro RAW_TX_TEST_PATTERN_EN adds input test_mode, which replaces
// the source with a (col + line) ramp for the whole frame it is sampled at.
module raw_stream_tx #(
    parameter int BITS   = 8,
    parameter int WIDTH  = 1936,
    parameter int HEIGHT = 1088,
    parameter int HBLANK = 64,
    parameter int VBLANK = 4
) (
    input  logic            pclk,
    input  logic            rst_n,
    input  logic            enable,
`ifdef RAW_TX_TEST_PATTERN_EN
    input  logic            test_mode,
`endif
    raw_stream_tx_if.slave  src,
    output logic [BITS-1:0] per_raw_data,
    output logic            per_raw_clken,
    output logic            frame_start,
    output logic            line_end,
    output logic            frame_done,
    output logic            underflow,
    input  logic            underflow_clr
);
    localparam int VB_CYC = VBLANK * (WIDTH + HBLANK);
    localparam int CW = WIDTH  > 1 ? $clog2(WIDTH)  : 1;
    localparam int LW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
    localparam int HW = HBLANK > 1 ? $clog2(HBLANK) : 1;
    localparam int VW = VB_CYC > 1 ? $clog2(VB_CYC) : 1;
    localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(HEIGHT - 1);
    localparam logic [HW-1:0] HB_LAST   = HW'(HBLANK - 1);
    localparam logic [VW-1:0] VB_LAST   = VW'(VB_CYC - 1);

    typedef enum logic [1:0] {IDLE, VBLANK_S, ACTIVE, HBLANK_S} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [LW-1:0]   line_q, line_d;
    logic [HW-1:0]   hb_q, hb_d;
    logic [VW-1:0]   vb_q, vb_d;
    logic            tm_q, tm_d;
    logic [BITS-1:0] data_q, data_d;
    logic            clken_q, clken_d;
    logic            fs_q, fs_d;
    logic            le_q, le_d;
    logic            fd_q, fd_d;
    logic            uf_q, uf_d;
    logic            col_last, line_last;
    logic [BITS-1:0] pat;

    assign col_last  = col_q == COL_LAST;
    assign line_last = line_q == LINE_LAST;
    assign pat       = BITS'(col_q) + BITS'(line_q);

    // Ready depends only on the state so the source can never stall an active line.
    assign src.src_ready = (state_q == ACTIVE) && !tm_q;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        line_d  = line_q;
        hb_d    = hb_q;
        vb_d    = vb_q;
        tm_d    = tm_q;
        data_d  = data_q;
        clken_d = 1'b0;
        fs_d    = 1'b0;
        le_d    = 1'b0;
        fd_d    = 1'b0;
        uf_d    = uf_q & ~underflow_clr;
        case (state_q)
            IDLE: state_d = enable ? VBLANK_S : IDLE;
            VBLANK_S: begin
                vb_d = vb_q == VB_LAST ? '0 : vb_q + 1'b1;
                if (vb_q == VB_LAST) begin
                    state_d = ACTIVE;
                    line_d  = '0;
                    col_d   = '0;
`ifdef RAW_TX_TEST_PATTERN_EN
                    tm_d    = test_mode;
`else
                    tm_d    = 1'b0;
`endif
                end
            end
            ACTIVE: begin
                clken_d = 1'b1;
                // An empty source still produces a strobe (zero pixel) to keep line length.
                data_d  = tm_q ? pat : (src.src_valid ? src.src_data : '0);
                uf_d    = (~tm_q & ~src.src_valid) | uf_d;
                fs_d    = col_q == '0 && line_q == '0;
                le_d    = col_last;
                fd_d    = col_last && line_last;
                col_d   = col_last ? '0 : col_q + 1'b1;
                state_d = col_last ? HBLANK_S : ACTIVE;
            end
            HBLANK_S: begin
                hb_d = hb_q == HB_LAST ? '0 : hb_q + 1'b1;
                if (hb_q == HB_LAST) begin
                    line_d  = line_last ? '0 : line_q + 1'b1;
                    state_d = !line_last ? ACTIVE : (enable ? VBLANK_S : IDLE);
                end
            end
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            line_q  <= '0;
            hb_q    <= '0;
            vb_q    <= '0;
            tm_q    <= 1'b0;
            data_q  <= '0;
            clken_q <= 1'b0;
            fs_q    <= 1'b0;
            le_q    <= 1'b0;
            fd_q    <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            line_q  <= line_d;
            hb_q    <= hb_d;
            vb_q    <= vb_d;
            tm_q    <= tm_d;
            data_q  <= data_d;
            clken_q <= clken_d;
            fs_q    <= fs_d;
            le_q    <= le_d;
            fd_q    <= fd_d;
            uf_q    <= uf_d;
        end
    end

    assign per_raw_data  = data_q;
    assign per_raw_clken = clken_q;
    assign frame_start   = fs_q;
    assign line_end      = le_q;
    assign frame_done    = fd_q;
    assign underflow     = uf_q;
endmodule

// File: tb/tb_raw_stream_tx.sv
// tb_raw_stream_tx: directed self-checking bench for raw_stream_tx (8x4 frame, HBLANK 3, VBLANK 2)
module tb_raw_stream_tx;
    logic       pclk = 1'b0;
    logic       rst_n, enable, underflow_clr;
    logic [7:0] per_raw_data;
    logic       per_raw_clken, frame_start, line_end, frame_done, underflow;
`ifdef RAW_TX_TEST_PATTERN_EN
    logic       test_mode = 1'b0;
`endif

    raw_stream_tx_if #(.BITS(8)) src_if ();

    raw_stream_tx #(.BITS(8), .WIDTH(8), .HEIGHT(4), .HBLANK(3), .VBLANK(2)) dut (
        .pclk          (pclk),
        .rst_n         (rst_n),
        .enable        (enable),
`ifdef RAW_TX_TEST_PATTERN_EN
        .test_mode     (test_mode),
`endif
        .src           (src_if),
        .per_raw_data  (per_raw_data),
        .per_raw_clken (per_raw_clken),
        .frame_start   (frame_start),
        .line_end      (line_end),
        .frame_done    (frame_done),
        .underflow     (underflow),
        .underflow_clr (underflow_clr)
    );

    always #5 pclk = ~pclk;

    int         total = 0, bad = 0;
    int         t, last, nfr, first, cnt, fs1, fs2;
    logic [7:0] nxt, e_data;
    bit         e_rdy, e_clk, e_fs, e_le, e_fd, e_uf, rdy_s, tm_b;
    logic [13:0] obs, expv;

    assign obs  = {rdy_s, per_raw_clken, frame_start, line_end, frame_done, underflow, per_raw_data};
    assign expv = {e_rdy, e_clk, e_fs, e_le, e_fd, e_uf, e_data};

    // Output strobe after edge tt: first pixel 23 edges after the enable edge, 66-edge frames,
    // 11-edge lines of which the first 8 carry pixels.
    function automatic bit active_at(int tt);
        int u;
        if (tt < 23) return 1'b0;
        u = tt - 23;
        if (u / 66 >= nfr) return 1'b0;
        u = u % 66;
        return u < 44 && (u % 11) < 8;
    endfunction

    task automatic step();
        int q;
        rdy_s = src_if.src_ready;
        e_clk = active_at(t);
        e_rdy = e_clk && !tm_b;
        {e_fs, e_le, e_fd} = 3'b000;
        if (e_clk) begin
            q = (t - 23) % 66;
            e_data = tm_b ? 8'(q / 11 + q % 11) : (src_if.src_valid ? nxt : 8'd0);
            e_fs = q == 0;
            e_le = q % 11 == 7;
            e_fd = q == 40;
        end
        e_uf = (e_clk && !tm_b && !src_if.src_valid) || (e_uf && !underflow_clr);
        if (e_clk && !tm_b && src_if.src_valid) nxt = nxt + 8'd1;
        @(posedge pclk);
        #1;
        last = t;
        t = t + 1;
        src_if.src_data = nxt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        underflow_clr = 1'b0;
        src_if.src_valid = 1'b1;
        src_if.src_data = 8'hA5;
        nxt = 8'd0;
        e_data = 8'd0;
        e_uf = 1'b0;
        tm_b = 1'b0;
        nfr = 0;
        t = 0;
        repeat (3) @(posedge pclk);
        #1;
        total++;
        if ({src_if.src_ready, per_raw_clken, frame_start, line_end, frame_done, underflow, per_raw_data} !== 14'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b_%h exp=0", obs[13:8], per_raw_data);
        end
        rst_n = 1'b1;
        src_if.src_data = nxt;
        repeat (3) begin
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL idle t=%0d got=%b_%h exp=%b_%h", last, obs[13:8], obs[7:0], expv[13:8], expv[7:0]);
            end
        end
    endtask

    task automatic test_basic_frame();
        t = 0;
        nfr = 4;
        first = -1;
        cnt = 0;
        enable = 1'b1;
        repeat (66) begin
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL basic t=%0d got=%b_%h exp=%b_%h", last, obs[13:8], obs[7:0], expv[13:8], expv[7:0]);
            end
            if (per_raw_clken) cnt++;
            if (per_raw_clken && first < 0) first = last;
            if (frame_start) fs1 = last;
        end
        total++;
        if (first !== 23) begin
            bad++;
            $display("FAIL first_clken got=%0d exp=23", first);
        end
        total++;
        if (cnt !== 32) begin
            bad++;
            $display("FAIL basic_strobes got=%0d exp=32", cnt);
        end
    endtask

    task automatic test_back_to_back();
        fs2 = -1;
        repeat (66) begin
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL b2b t=%0d got=%b_%h exp=%b_%h", last, obs[13:8], obs[7:0], expv[13:8], expv[7:0]);
            end
            if (frame_start) begin
                fs2 = last;
                total++;
                if (per_raw_data !== 8'd32) begin
                    bad++;
                    $display("FAIL b2b_first_pixel got=%h exp=20", per_raw_data);
                end
            end
        end
        total++;
        if (fs2 - fs1 !== 66) begin
            bad++;
            $display("FAIL frame_period got=%0d exp=66", fs2 - fs1);
        end
    endtask

    task automatic test_underflow();
        cnt = 0;
        repeat (66) begin
            src_if.src_valid = t != 169;
            underflow_clr = t == 180;
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL underflow t=%0d got=%b_%h exp=%b_%h", last, obs[13:8], obs[7:0], expv[13:8], expv[7:0]);
            end
            if (last >= 165 && last <= 175 && per_raw_clken) cnt++;
            if (last == 169) begin
                total++;
                if ({per_raw_clken, per_raw_data, underflow} !== {1'b1, 8'd0, 1'b1}) begin
                    bad++;
                    $display("FAIL dropped_pixel got clk=%b data=%h uf=%b exp 1/00/1", per_raw_clken, per_raw_data, underflow);
                end
            end
        end
        src_if.src_valid = 1'b1;
        underflow_clr = 1'b0;
        total++;
        if (cnt !== 8) begin
            bad++;
            $display("FAIL underflow_line_len got=%0d exp=8", cnt);
        end
    endtask

    task automatic test_stop_mid_frame();
        cnt = 0;
        while (t <= 300) begin
            enable = t < 232;
            src_if.src_valid = t != 245;
            underflow_clr = t == 245 || t == 270;
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL stop t=%0d got=%b_%h exp=%b_%h", last, obs[13:8], obs[7:0], expv[13:8], expv[7:0]);
            end
            if (per_raw_clken) cnt++;
            if (last == 245) begin
                total++;
                if (underflow !== 1'b1) begin
                    bad++;
                    $display("FAIL set_beats_clear got=%b exp=1", underflow);
                end
            end
        end
        src_if.src_valid = 1'b1;
        underflow_clr = 1'b0;
        total++;
        if (cnt !== 32) begin
            bad++;
            $display("FAIL stop_strobes got=%0d exp=32", cnt);
        end
    endtask

    task automatic test_reset_mid_line();
        t = 0;
        nfr = 1;
        enable = 1'b1;
        while (t <= 48) begin
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL pre_reset t=%0d got=%b_%h exp=%b_%h", last, obs[13:8], obs[7:0], expv[13:8], expv[7:0]);
            end
        end
        total++;
        if (per_raw_clken !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_clken got=%b exp=1", per_raw_clken);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({src_if.src_ready, per_raw_clken, frame_start, line_end, frame_done, underflow, per_raw_data} !== 14'd0) begin
            bad++;
            $display("FAIL async_reset got rdy=%b clk=%b data=%h exp 0", src_if.src_ready, per_raw_clken, per_raw_data);
        end
        repeat (2) @(posedge pclk);
        #1;
        rst_n = 1'b1;
        e_data = 8'd0;
        e_uf = 1'b0;
        t = 0;
    endtask

    task automatic test_fresh_frame();
        first = -1;
        cnt = 0;
        repeat (70) begin
            enable = t < 30;
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL fresh t=%0d got=%b_%h exp=%b_%h", last, obs[13:8], obs[7:0], expv[13:8], expv[7:0]);
            end
            if (per_raw_clken) cnt++;
            if (per_raw_clken && first < 0) first = last;
        end
        total++;
        if (first !== 23 || cnt !== 32) begin
            bad++;
            $display("FAIL fresh_frame got first=%0d strobes=%0d exp 23/32", first, cnt);
        end
    endtask

`ifdef RAW_TX_TEST_PATTERN_EN
    task automatic test_pattern();
        t = 0;
        nfr = 1;
        tm_b = 1'b1;
        test_mode = 1'b1;
        src_if.src_valid = 1'b0;
        repeat (70) begin
            enable = t < 30;
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL pattern t=%0d got=%b_%h exp=%b_%h", last, obs[13:8], obs[7:0], expv[13:8], expv[7:0]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_underflow();
        test_stop_mid_frame();
        test_reset_mid_line();
        test_fresh_frame();
`ifdef RAW_TX_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/raw_stream_tx.md
Name: raw_stream_tx

Overview:
- Frame-timing transmitter that produces the raw Bayer pixel stream consumed by the ISP filter chain (per_raw_data / per_raw_clken).
- Pulls pixels from an upstream source (SD-card reader FIFO) over a valid/ready handshake.
- Emits them as continuous active lines separated by horizontal and vertical blanking.
- Downstream line buffers and windows shift every clock, so the block guarantees gap-free active lines.

Parameters:
BITS, 8, pixel width
WIDTH, 1936, active pixels per line
HEIGHT, 1088, active lines per frame
HBLANK, 64, blanking cycles after each active line (>=1)
VBLANK, 4, blanking lines before each frame (>=1); each lasts WIDTH+HBLANK cycles

Ports:
pclk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run request; sampled only at frame boundaries
src_data  in  BITS  upstream pixel
src_valid  in  1  upstream pixel available
src_ready  out  1  block accepts src_data this cycle
per_raw_data  out  BITS  registered output pixel
per_raw_clken  out  1  registered active-pixel strobe
frame_start  out  1  one-cycle pulse with first pixel of frame
line_end  out  1  one-cycle pulse with last pixel of each line
frame_done  out  1  one-cycle pulse with last pixel of frame
underflow  out  1  sticky: src_valid low during an active cycle
underflow_clr  in  1  synchronous clear of underflow

Behaviour:
- Reset and clock: rst_n asynchronous, active-low; clock pclk. Reset forces state IDLE, all counters 0, and every output 0.
- State machine:
  - IDLE: if enable, go to VBLANK.
  - VBLANK: run VBLANK*(WIDTH+HBLANK) cycles, then go to ACTIVE with line=0.
  - ACTIVE: run WIDTH cycles with col 0..WIDTH-1, then go to HBLANK.
  - HBLANK: run HBLANK cycles. Then, if line<HEIGHT-1, line++ and go to ACTIVE. Otherwise, if enable, go to VBLANK; else go to IDLE.
- Frame period: (VBLANK+HEIGHT)*(WIDTH+HBLANK) cycles.
- src_ready is combinational and equals (state==ACTIVE). It does not depend on src_valid.
- Output pipeline: each ACTIVE cycle registers per_raw_clken=1 on the next edge, so latency from the ACTIVE cycle to the output is 1 clock.
  - src_valid=1: per_raw_data = src_data.
  - src_valid=0: per_raw_data = 0, per_raw_clken still 1, underflow set. No stall, so line length is preserved.
- Outside ACTIVE: per_raw_clken=0 and per_raw_data holds its last value.
- Pulses (same registered cycle as the corresponding pixel):
  - frame_start: col=0, line=0.
  - line_end: col=WIDTH-1.
  - frame_done: col=WIDTH-1, line=HEIGHT-1.
- underflow: sticky until underflow_clr. If set and clear occur in the same cycle, set wins.
- enable deasserted mid-frame: the current frame completes, including the final HBLANK, then the block goes to IDLE. Frames are never truncated.
- enable re-asserted during the last HBLANK: the block continues straight to VBLANK.
- Counter widths: $clog2 of each maximum. Every counter wraps to 0 exactly at its terminal count.

Optional Feature:
- Macro: RAW_TX_TEST_PATTERN_EN.
- Defined:
  - Adds input test_mode (1 bit), which is sampled at frame start only.
  - When test_mode=1, per_raw_data = (col + line) truncated to BITS.
  - src_ready is held 0 and underflow is never set.
- Undefined: the test_mode port is absent and behaviour is as above.

Test Plan:
- Bench parameters: WIDTH=8, HEIGHT=4, HBLANK=3, VBLANK=2, so the frame period is 66 cycles.
- Basic frame: enable=1, src_valid=1, incrementing src_data from 0.
  - First per_raw_clken appears 23 cycles after the first enable edge.
  - 4 bursts of exactly 8 clken-high cycles, each followed by 3 low cycles.
  - Data runs 0..31 in order.
  - frame_start on pixel 0; line_end on pixels 7/15/23/31; frame_done on pixel 31.
- Back-to-back: enable held high for 2 frames. The second frame_start comes exactly 66 cycles after the first, and data continues 32..63.
- Underflow: drop src_valid for col 3 of line 1.
  - That output pixel is 0 with clken=1, the line still has 8 strobes, and underflow=1.
  - underflow stays set until an underflow_clr pulse, then reads 0.
- Stop mid-frame: deassert enable at line 1.
  - Frame completes all 32 pixels, state returns to IDLE, and no further clken.
  - src_ready stays 0 afterwards.
- Reset mid-line: assert rst_n=0 at col 4 of line 2.
  - All outputs go to 0 immediately.
  - After release with enable=1, a full fresh frame starts with VBLANK (first clken again 23 cycles after enable).
- Test pattern (macro defined, test_mode=1): output per line L is L..L+7, src_ready stays 0, and underflow stays 0.
